// File: rtl/io_master.sv
// ============================================================================
// Module      : io_master
// Description : Four-phase handshake I/O master. Runs one INP (read from the
//               input unit) or OUT (write to the output unit) transaction per
//               accepted start request and pulses done when it ends.
//               Optional macro IO_TIMEOUT_EN adds a per-phase wait timeout
//               that aborts a transaction and sets a sticky timeout_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_master #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_inp,
    input  logic          start_out,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic          inp_req,
    input  logic [DW-1:0] inp_data,
    input  logic          inp_ack,
    output logic          out_req,
    output logic [DW-1:0] out_data,
    input  logic          out_ack
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INP_REQ = 3'd1;
    localparam logic [2:0] S_INP_REL = 3'd2;
    localparam logic [2:0] S_OUT_REQ = 3'd3;
    localparam logic [2:0] S_OUT_REL = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0] state;
    logic       wait_expired;

`ifdef IO_TIMEOUT_EN
    // The counter holds the number of cycles already spent in the current
    // wait state, so expiry one short of TIMEOUT gives exactly TIMEOUT cycles.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;
    logic       wait_leave;

    assign wait_expired = (wait_cnt == WAIT_LIMIT);

    // Decide whether the FSM leaves (or is not in) a wait state this cycle.
    always_comb begin
        wait_leave = 1'b1;
        case (state)
            S_INP_REQ: wait_leave = inp_ack  || wait_expired;
            S_INP_REL: wait_leave = !inp_ack || wait_expired;
            S_OUT_REQ: wait_leave = out_ack  || wait_expired;
            S_OUT_REL: wait_leave = !out_ack || wait_expired;
            default:   wait_leave = 1'b1;
        endcase
    end

    // Wait counter: zero on entry to each REQ/REL state, counts while staying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (wait_leave) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    // No timeout: REQ and REL states wait for the peer indefinitely.
    assign wait_expired = 1'b0;
`endif

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            inp_req     <= 1'b0;
            out_req     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            rd_data     <= '0;
            out_data    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A peer still holding ack from an earlier (possibly
                    // reset-aborted) handshake blocks new starts.
                    if (!inp_ack && !out_ack) begin
                        if (start_inp) begin
                            state       <= S_INP_REQ;
                            inp_req     <= 1'b1;
                            busy        <= 1'b1;
                            timeout_err <= 1'b0;
                        end else if (start_out) begin
                            state       <= S_OUT_REQ;
                            out_req     <= 1'b1;
                            out_data    <= wr_data;
                            busy        <= 1'b1;
                            timeout_err <= 1'b0;
                        end
                    end
                end
                S_INP_REQ: begin
                    if (inp_ack) begin
                        rd_data <= inp_data;
                        inp_req <= 1'b0;
                        state   <= S_INP_REL;
                    end else if (wait_expired) begin
                        inp_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_INP_REL: begin
                    if (!inp_ack) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_OUT_REQ: begin
                    if (out_ack) begin
                        out_req <= 1'b0;
                        state   <= S_OUT_REL;
                    end else if (wait_expired) begin
                        out_req     <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_OUT_REL: begin
                    if (!out_ack) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (wait_expired) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    inp_req <= 1'b0;
                    out_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
